// File: rtl/pa_fpu.sv
// Shared FPU types and field widths for the Sol-1 floating-point datapath.
package pa_fpu;

    typedef enum logic [1:0] {
        norm_idle_st  = 2'd0,
        norm_shift_st = 2'd1,
        norm_round_st = 2'd2,
        norm_done_st  = 2'd3
    } e_norm_state;

    localparam logic [7:0] EXP_INF    = 8'hFF;
    localparam int         EXP_BIAS   = 127;
    localparam int         FRAC_W     = 23;
    localparam int         MANT_EXT_W = 27;

endpackage

// File: rtl/fpu_normalize_round.sv
// Round-to-nearest-even on a normalised 24-bit significand plus guard/sticky,
// with exponent bump on round carry and overflow to signed infinity.
module fpu_round_rne
    import pa_fpu::*;
(
    input  logic [25:0] i_mant,
    input  logic [8:0]  i_exp,
    input  logic        i_sign,
    output logic [31:0] o_result,
    output logic        o_ovf,
    output logic        o_inexact
);

    logic        w_round_up;
    logic [24:0] w_frac25;
    logic [8:0]  w_exp_adj;

    // Round decision, significand increment and exponent adjust on carry-out.
    always_comb begin
        w_round_up = i_mant[1] & (i_mant[0] | i_mant[2]);
        w_frac25   = {1'b0, i_mant[25:2]} + {24'd0, w_round_up};
        w_exp_adj  = i_exp + {8'd0, w_frac25[24]};
        o_ovf      = (w_exp_adj >= {1'b0, EXP_INF});
        o_inexact  = i_mant[1] | i_mant[0] | o_ovf;
        if (o_ovf)
            o_result = {i_sign, EXP_INF, {FRAC_W{1'b0}}};
        else
            o_result = {i_sign, w_exp_adj[7:0], w_frac25[FRAC_W-1:0]};
    end

endmodule

// File: rtl/fpu_normalize.sv
// Post-add normalise/round stage: one-bit shift per clock, RNE rounding,
// overflow to infinity and flush of subnormal results to signed zero.
//
// state          | meaning
// norm_idle_st   | waiting for a raw result, in_ready high
// norm_shift_st  | normalising one bit per clock, zero/flush/overflow checks
// norm_round_st  | applying round-to-nearest-even, assembling result
// norm_done_st   | result held until out_ready
module fpu_normalize
    import pa_fpu::*;
#(
    parameter int FLUSH_DENORM = 1
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [7:0]            in_exp,
    input  logic [MANT_EXT_W-1:0] in_mant,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_result,
    output logic                  out_ovf,
    output logic                  out_unf,
    output logic                  out_inexact,
    output logic                  busy
);

    e_norm_state           r_state;
    logic                  r_sign;
    logic [8:0]            r_exp;
    logic [MANT_EXT_W-1:0] r_mant;
    logic [31:0]           r_result;
    logic                  r_ovf;
    logic                  r_unf;
    logic                  r_inexact;

    logic [MANT_EXT_W-1:0] w_mant_rsh;
    logic [8:0]            w_exp_inc;
    logic [31:0]           w_rnd_result;
    logic                  w_rnd_ovf;
    logic                  w_rnd_inexact;

    // Carry fold-back: the bit dropped off the bottom is kept in sticky.
    always_comb begin
        w_mant_rsh = {1'b0, r_mant[MANT_EXT_W-1:2], r_mant[1] | r_mant[0]};
        w_exp_inc  = r_exp + 9'd1;
    end

    fpu_round_rne u_round (
        .i_mant    (r_mant[25:0]),
        .i_exp     (r_exp),
        .i_sign    (r_sign),
        .o_result  (w_rnd_result),
        .o_ovf     (w_rnd_ovf),
        .o_inexact (w_rnd_inexact)
    );

    // Sequencer: accept, shift-normalise, round, hold result for the consumer.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state   <= norm_idle_st;
            r_sign    <= 1'b0;
            r_exp     <= 9'd0;
            r_mant    <= '0;
            r_result  <= 32'd0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_inexact <= 1'b0;
        end else begin
            case (r_state)
                norm_idle_st: begin
                    if (in_valid) begin
                        r_sign    <= in_sign;
                        r_exp     <= {1'b0, in_exp};
                        r_mant    <= in_mant;
                        r_ovf     <= 1'b0;
                        r_unf     <= 1'b0;
                        r_inexact <= 1'b0;
                        r_state   <= norm_shift_st;
                    end
                end
                norm_shift_st: begin
                    if (r_mant == '0) begin
                        r_result <= {r_sign, 31'd0};
                        r_state  <= norm_done_st;
                    end else if (r_mant[26]) begin
                        r_mant <= w_mant_rsh;
                        r_exp  <= w_exp_inc;
                        if (w_exp_inc == {1'b0, EXP_INF}) begin
                            r_result  <= {r_sign, EXP_INF, {FRAC_W{1'b0}}};
                            r_ovf     <= 1'b1;
                            r_inexact <= 1'b1;
                            r_state   <= norm_done_st;
                        end else begin
                            r_state <= norm_round_st;
                        end
                    end else if (r_mant[25]) begin
                        r_state <= norm_round_st;
                    end else if (r_exp <= 9'd1) begin
                        // Too small for a normal: flush to signed zero.
                        r_result  <= {r_sign, 31'd0};
                        r_unf     <= (FLUSH_DENORM != 0);
                        r_inexact <= 1'b1;
                        r_state   <= norm_done_st;
                    end else begin
                        r_mant <= {r_mant[MANT_EXT_W-2:0], 1'b0};
                        r_exp  <= r_exp - 9'd1;
                    end
                end
                norm_round_st: begin
                    r_result  <= w_rnd_result;
                    r_ovf     <= w_rnd_ovf;
                    r_inexact <= r_inexact | w_rnd_inexact;
                    r_state   <= norm_done_st;
                end
                norm_done_st: begin
                    if (out_ready)
                        r_state <= norm_idle_st;
                end
                default: r_state <= norm_idle_st;
            endcase
        end
    end

    assign in_ready    = (r_state == norm_idle_st);
    assign out_valid   = (r_state == norm_done_st);
    assign busy        = (r_state != norm_idle_st);
    assign out_result  = r_result;
    assign out_ovf     = r_ovf;
    assign out_unf     = r_unf;
    assign out_inexact = r_inexact;

endmodule
